dma_m2s: RTL and testbench

// - Memory-to-stream DMA engine feeding the dnn_engine AXI-Stream slave ports (pixels, weights).
// - Accepts {base address, byte count}, reads BUS_WIDTH-bit words from a synchronous memory port,
//   and emits them as an AXI-Stream packet with TKEEP and TLAST. Pulses done when the packet ends.
// - Optional pseudo-random TVALID throttling (VALID_PROB) stresses downstream backpressure logic.

---
 rtl/dma_pkg.sv | 35 +++
 rtl/lfsr_throttle.sv | 38 +++
 rtl/dma_m2s.sv | 167 ++++++++++++++++
 tb/tb_dma_m2s.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and helpers for the memory-to-stream DMA engine.
package dma_pkg;

    // Engine sequencing states; encodings kept fixed for waveform compatibility.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } dma_state_e;

    // Throttle LFSR: 16-bit Galois, taps 16,14,13,11 (right-shifting form).
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Widest byte-enable vector the helper can produce (512-bit bus).
    localparam int KEEP_MAX = 64;

    // Byte-enable mask for a beat with 'rem' bytes left on an 'nb'-byte bus:
    // all ones when rem >= nb, otherwise the low 'rem' lanes.
    function automatic logic [KEEP_MAX-1:0] keep_mask(input logic [63:0] rem, input int nb);
        logic [KEEP_MAX-1:0] m;
        m = {KEEP_MAX{1'b0}};
        for (int i = 0; i < KEEP_MAX; i++) begin
            if ((i < nb) && (64'(i) < rem)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_throttle.sv
// Pseudo-random permission source for TVALID throttling.
// ok is high when the low ten LFSR bits fall below PROB (out of 1024).
module lfsr_throttle
    import dma_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int          PROB = 1024
) (
    input  logic clk,
    input  logic rst,
    output logic ok
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next LFSR value: shift right, fold taps back in when a one falls out.
    always_comb begin
        if (lfsr_q[0]) begin
            lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ LFSR_TAPS;
        end else begin
            lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]};
        end
    end

    // LFSR state; free-running every cycle regardless of engine state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Eleven-bit compare so that PROB = 1024 always grants.
    assign ok = ({1'b0, lfsr_q[9:0]} < 11'(PROB));

endmodule

// File: rtl/dma_m2s.sv
// Memory-to-stream DMA: reads NB-byte words from a 1-cycle-latency memory
// port and emits them as one AXI-Stream packet with TKEEP/TLAST, then
// pulses done. One beat takes READ -> WAIT -> SEND, so at most 1 beat per 3 cycles.
module dma_m2s
    import dma_pkg::*;
#(
    parameter int          BUS_WIDTH  = 128,
    parameter int          VALID_PROB = 1024,
    parameter int          ADDR_W     = 32,
    parameter int          LEN_W      = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [LEN_W-1:0]       cmd_bytes,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [BUS_WIDTH-1:0]   mem_rdata,
    output logic                   tvalid,
    input  logic                   tready,
    output logic [BUS_WIDTH-1:0]   tdata,
    output logic [BUS_WIDTH/8-1:0] tkeep,
    output logic                   tlast,
    output logic                   done
);

    localparam int                NB         = BUS_WIDTH / 8;
    localparam logic [LEN_W-1:0]  NB_LEN     = LEN_W'(NB);
    localparam logic [ADDR_W-1:0] NB_ADDR    = ADDR_W'(NB);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(NB - 1));

    dma_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 tvalid_q, tvalid_d;
    logic [BUS_WIDTH-1:0] tdata_q, tdata_d;
    logic [NB-1:0]        tkeep_q, tkeep_d;
    logic                 tlast_q, tlast_d;
    logic                 done_q, done_d;
    logic [NB-1:0]        keep_s;
    logic                 ok_s;

    lfsr_throttle #(
        .SEED (LFSR_SEED),
        .PROB (VALID_PROB)
    ) u_throttle (
        .clk (aclk),
        .rst (areset),
        .ok  (ok_s)
    );

    // Lanes still belonging to the packet for the beat being captured.
    always_comb begin
        keep_s = NB'(keep_mask(64'(rem_q), NB));
    end

    // Sequencing, counters and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ALIGN_MASK;
                    rem_d   = cmd_bytes;
                    state_d = (cmd_bytes == {LEN_W{1'b0}}) ? FIN : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Read data is valid now; lanes past the end are zeroed.
                for (int i = 0; i < NB; i++) begin
                    tdata_d[8*i +: 8] = keep_s[i] ? mem_rdata[8*i +: 8] : 8'h00;
                end
                tkeep_d  = keep_s;
                tlast_d  = (rem_q <= NB_LEN);
                tvalid_d = ok_s;
                state_d  = SEND;
            end
            SEND: begin
                if (tvalid_q && tready) begin
                    tvalid_d = 1'b0;
                    if (tlast_q) begin
                        tdata_d = {BUS_WIDTH{1'b0}};
                        tkeep_d = {NB{1'b0}};
                        tlast_d = 1'b0;
                        state_d = FIN;
                    end else begin
                        rem_d   = rem_q - NB_LEN;
                        addr_d  = addr_q + NB_ADDR;
                        state_d = READ;
                    end
                end else if (!tvalid_q) begin
                    // Pending beat waits for throttle permission.
                    tvalid_d = ok_s;
                end else begin
                    // Raised valid is never withdrawn before the handshake.
                    tvalid_d = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
        mem_en_d    = (state_d == READ);
        mem_addr_d  = (state_d == READ) ? addr_d : {ADDR_W{1'b0}};
        done_d      = (state_d == FIN);
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            rem_q       <= {LEN_W{1'b0}};
            cmd_ready_q <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            tvalid_q    <= 1'b0;
            tdata_q     <= {BUS_WIDTH{1'b0}};
            tkeep_q     <= {NB{1'b0}};
            tlast_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cmd_ready_q <= cmd_ready_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign tvalid    = tvalid_q;
    assign tdata     = tdata_q;
    assign tkeep     = tkeep_q;
    assign tlast     = tlast_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dma_m2s.sv
// Bench for dma_m2s on a 32-bit bus where memory byte at address a holds a[7:0].
// Instance 0 is unthrottled, instance 1 uses VALID_PROB = 512.
module tb_dma_m2s;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [31:0] cmd_addr  [2];
    logic [31:0] cmd_bytes [2];
    logic        mem_en    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_rdata [2];
    logic        tvalid    [2];
    logic        tready    [2];
    logic [31:0] tdata     [2];
    logic [3:0]  tkeep     [2];
    logic        tlast     [2];
    logic        done      [2];

    always #5 clk = ~clk;

    dma_m2s #(.BUS_WIDTH(32), .VALID_PROB(1024), .ADDR_W(32), .LEN_W(32), .LFSR_SEED(16'hACE1)) dut0 (
        .aclk(clk), .areset(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_addr(cmd_addr[0]), .cmd_bytes(cmd_bytes[0]), .mem_en(mem_en[0]), .mem_addr(mem_addr[0]),
        .mem_rdata(mem_rdata[0]), .tvalid(tvalid[0]), .tready(tready[0]), .tdata(tdata[0]),
        .tkeep(tkeep[0]), .tlast(tlast[0]), .done(done[0]));

    dma_m2s #(.BUS_WIDTH(32), .VALID_PROB(512), .ADDR_W(32), .LEN_W(32), .LFSR_SEED(16'hACE1)) dut1 (
        .aclk(clk), .areset(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_addr(cmd_addr[1]), .cmd_bytes(cmd_bytes[1]), .mem_en(mem_en[1]), .mem_addr(mem_addr[1]),
        .mem_rdata(mem_rdata[1]), .tvalid(tvalid[1]), .tready(tready[1]), .tdata(tdata[1]),
        .tkeep(tkeep[1]), .tlast(tlast[1]), .done(done[1]));

    int total = 0;
    int bad   = 0;

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    beat_t log0[$];
    bit    busy [2];
    bit    due  [2];
    bit    held [2];
    beat_t prev [2];
    int    hs_cnt [2];
    int    last_cnt [2];
    int    done_cnt [2];
    int    low_run [2];
    int    max_run [2];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            w[8*j +: 8] = 8'(a + 32'(j));
        end
        return w;
    endfunction

    // Synchronous memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mem_rdata[i] <= mem_en[i] ? mem_word(mem_addr[i]) : 32'hDEADBEEF;
        end
    end

    function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h (t=%0t)", name, inst, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Expected packet from the command alone: ceil(bytes/4) beats of consecutive memory bytes.
    task automatic push_beats(input int i, input logic [31:0] addr, input logic [31:0] nbytes);
        longint      nbeats;
        longint      idx;
        logic [31:0] base;
        beat_t       e;
        nbeats = (longint'(nbytes) + 64'd3) / 64'd4;
        base   = addr & 32'hFFFF_FFFC;
        for (longint b = 0; b < nbeats; b++) begin
            e = '0;
            for (int j = 0; j < 4; j++) begin
                idx = b * 4 + j;
                if (idx < longint'(nbytes)) begin
                    e.data[8*j +: 8] = 8'(base + 32'(idx));
                    e.keep[j]        = 1'b1;
                end
            end
            e.last = (b == nbeats - 1);
            if (i == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
    endtask

    task automatic check_inst(input int i);
        beat_t cur;
        beat_t e;
        bit    due_next;
        cur = {tdata[i], tkeep[i], tlast[i]};
        if (rst) begin
            chk("rst_tvalid", i, 64'(tvalid[i]), 64'd0);
            chk("rst_cmd_ready", i, 64'(cmd_ready[i]), 64'd1);
            chk("rst_done", i, 64'(done[i]), 64'd0);
            chk("rst_mem_en", i, 64'(mem_en[i]), 64'd0);
            chk("rst_outputs", i, 64'(cur), 64'd0);
            busy[i] = 1'b0; due[i] = 1'b0; held[i] = 1'b0; low_run[i] = 0;
            if (i == 0) exp_q0.delete();
            else        exp_q1.delete();
            return;
        end
        due_next = 1'b0;
        chk("cmd_ready", i, 64'(cmd_ready[i]), 64'(!busy[i]));
        chk("done", i, 64'(done[i]), 64'(due[i]));
        if (held[i]) begin
            chk("hold_tvalid", i, 64'(tvalid[i]), 64'd1);
            chk("hold_beat", i, 64'(cur), 64'(prev[i]));
        end
        if (!busy[i] || qsize(i) == 0) chk("tvalid_no_beat", i, 64'(tvalid[i]), 64'd0);
        if (!busy[i] || done[i]) chk("idle_outputs", i, 64'(cur), 64'd0);
        if (mem_en[i]) chk("mem_addr_align", i, 64'(mem_addr[i][1:0]), 64'd0);
        if (tvalid[i] && tready[i]) begin
            if (qsize(i) == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat[%0d]: got %0h want none (t=%0t)", i, cur, $time);
            end else begin
                if (i == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                chk("beat", i, 64'(cur), 64'(e));
                if (e.last) due_next = 1'b1;
            end
            hs_cnt[i]++;
            if (tlast[i]) last_cnt[i]++;
            if (i == 0) log0.push_back(cur);
        end
        held[i] = tvalid[i] && !tready[i];
        prev[i] = cur;
        if (!busy[i] || tvalid[i]) begin
            low_run[i] = 0;
        end else begin
            low_run[i]++;
            if (low_run[i] > max_run[i]) max_run[i] = low_run[i];
        end
        if (done[i]) begin
            busy[i] = 1'b0;
            done_cnt[i]++;
        end
        if (cmd_valid[i] && cmd_ready[i]) begin
            push_beats(i, cmd_addr[i], cmd_bytes[i]);
            busy[i] = 1'b1;
            if (cmd_bytes[i] == 32'd0) due_next = 1'b1;
        end
        due[i] = due_next;
    endtask

    // Single compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        check_inst(0);
        check_inst(1);
    end

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] n);
        @(posedge clk); #1;
        cmd_valid[i] = 1'b1; cmd_addr[i] = a; cmd_bytes[i] = n;
        @(posedge clk); #1;
        cmd_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while (busy[i] && n < budget) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (busy[i]) begin
            bad++;
            $display("FAIL idle_timeout[%0d]: got busy after %0d cycles want idle", i, n);
        end
    endtask

    task automatic check_s1_log(input string tag);
        chk({tag, "_beats"}, 0, 64'(log0.size()), 64'd2);
        chk({tag, "_beat1"}, 0, 64'(log0[0]), 64'(mk(32'h03020100, 4'hF, 1'b0)));
        chk({tag, "_beat2"}, 0, 64'(log0[1]), 64'(mk(32'h07060504, 4'hF, 1'b1)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000");
        $fatal(1);
    end

    initial begin
        int n;
        int h;
        int d;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_addr[i] = 32'd0; cmd_bytes[i] = 32'd0; tready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_cmd_ready", 0, 64'(cmd_ready[0]), 64'd1);
        chk("post_reset_tvalid", 0, 64'(tvalid[0]), 64'd0);

        // Scenario 1: 8 bytes at 0x100, first valid 3 cycles after accept.
        log0.delete();
        issue(0, 32'h100, 32'd8);
        @(negedge clk); @(negedge clk);
        chk("s1_no_valid_yet", 0, 64'(tvalid[0]), 64'd0);
        @(negedge clk);
        chk("s1_first_valid", 0, 64'(tvalid[0]), 64'd1);
        wait_idle(0, 100);
        check_s1_log("s1");
        chk("s1_done_cnt", 0, 64'(done_cnt[0]), 64'd1);

        // Scenario 2: 6 bytes at 0 -> short final beat.
        log0.delete();
        issue(0, 32'h0, 32'd6);
        wait_idle(0, 100);
        chk("s2_beats", 0, 64'(log0.size()), 64'd2);
        chk("s2_beat1", 0, 64'(log0[0]), 64'(mk(32'h03020100, 4'hF, 1'b0)));
        chk("s2_beat2", 0, 64'(log0[1]), 64'(mk(32'h00000504, 4'b0011, 1'b1)));

        // Scenario 3: zero-length command.
        h = hs_cnt[0];
        d = done_cnt[0];
        issue(0, 32'h20, 32'd0);
        @(negedge clk);
        chk("s3_done_next_cycle", 0, 64'(done[0]), 64'd1);
        wait_idle(0, 20);
        chk("s3_no_beats", 0, 64'(hs_cnt[0]), 64'(h));
        chk("s3_one_done", 0, 64'(done_cnt[0]), 64'(d + 1));
        @(posedge clk); #1;
        chk("s3_cmd_ready", 0, 64'(cmd_ready[0]), 64'd1);

        // Scenario 4: backpressure for 10 cycles with tvalid high.
        log0.delete();
        tready[0] = 1'b0;
        issue(0, 32'h40, 32'd8);
        n = 0;
        while (!tvalid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s4_valid_seen", 0, 64'(tvalid[0]), 64'd1);
        repeat (10) @(negedge clk);
        chk("s4_still_valid", 0, 64'(tvalid[0]), 64'd1);
        chk("s4_held_beat", 0, 64'(mk(tdata[0], tkeep[0], tlast[0])), 64'(mk(32'h43424140, 4'hF, 1'b0)));
        @(posedge clk); #1;
        tready[0] = 1'b1;
        wait_idle(0, 100);
        chk("s4_beats", 0, 64'(log0.size()), 64'd2);
        chk("s4_beat2", 0, 64'(log0[1]), 64'(mk(32'h47464544, 4'hF, 1'b1)));

        // Scenario 5: throttled instance, 256 bytes.
        issue(1, 32'h0, 32'd256);
        wait_idle(1, 3000);
        chk("s5_beats", 1, 64'(hs_cnt[1]), 64'd64);
        chk("s5_tlast_count", 1, 64'(last_cnt[1]), 64'd1);
        chk("s5_done_count", 1, 64'(done_cnt[1]), 64'd1);
        chk("s5_throttle_gap", 1, 64'(max_run[1] >= 3), 64'd1);
        chk("unthrottled_gap", 0, 64'(max_run[0]), 64'd2);

        // Scenario 6: reset while beat 4 of a 64-byte packet is pending.
        h = hs_cnt[0];
        issue(0, 32'h200, 32'd64);
        n = 0;
        while ((hs_cnt[0] - h) < 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        while (!tvalid[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("s6_beat4_valid", 0, 64'(tvalid[0]), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("s6_tvalid_drops", 0, 64'(tvalid[0]), 64'd0);
        d = done_cnt[0];
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("s6_no_done", 0, 64'(done_cnt[0]), 64'(d));
        chk("s6_cmd_ready", 0, 64'(cmd_ready[0]), 64'd1);
        log0.delete();
        issue(0, 32'h100, 32'd8);
        wait_idle(0, 100);
        check_s1_log("s6");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
